seq_detect_ctrl: RTL
====================

Name: seq_detect_ctrl

Overview:
- Programmable serial pattern-detect controller.
- Accepts parallel data words over a valid/ready handshake and serializes each word MSB-first into a bit history.
- Compares the most recent cfg_len bits against a programmable pattern, counts matches, and stops after a configured match target.
- Sits between a word-wide data source and the detect flag/interrupt logic; replaces fixed-pattern detectors with a single run-time-configured engine.

Parameters:
- DW, 8, input word width in bits.
- PW, 8, maximum pattern length in bits.
- CW, 8, match counter / target width.

Ports:
- clk, input, 1, clock; all state updates on rising edge.
- rst, input, 1, asynchronous reset, active-high.
- start, input, 1, begin a run; sampled in IDLE only.
- abort, input, 1, terminate a run; sampled in any non-IDLE state.
- cfg_pattern, input, PW, pattern; bit [cfg_len-1] is compared against the oldest bit.
- cfg_len, input, $clog2(PW)+1, pattern length in bits.
- cfg_overlap, input, 1, 1 = overlapping matches allowed.
- cfg_target, input, CW, match count that ends the run; 0 = run until abort.
- s_valid, input, 1, data word valid.
- s_data, input, DW, data word.
- s_ready, output, 1, controller accepts a word.
- flag, output, 1, one-cycle pulse per match.
- match_cnt, output, CW, matches in the current run.
- busy, output, 1, high in any state other than IDLE.
- done, output, 1, one-cycle pulse when cfg_target is reached.

Behaviour:
- Reset (async, rst=1): state=IDLE. s_ready, flag, busy, done, match_cnt, history, bits_seen and bit counter all 0.
- States: IDLE, LOAD, SHIFT, DONE.
- IDLE:
  - On start=1, latch cfg_pattern/cfg_len/cfg_overlap/cfg_target.
  - Clear history, bits_seen and match_cnt, then go to LOAD.
  - cfg_* changes outside IDLE are ignored.
- LOAD:
  - s_ready=1 (combinational from state).
  - On s_valid&s_ready, capture s_data, set bit counter to DW-1, go to SHIFT.
  - No transfer: stay in LOAD.
- SHIFT:
  - s_ready=0.
  - Each cycle, shift the next word bit (MSB first) into the history LSB; bits_seen increments and saturates at PW.
  - Match condition: bits_seen (including this bit) >= len_eff, and the low len_eff bits of the new history equal the low len_eff bits of the pattern.
  - After the bit with index 0, go to LOAD.
  - Throughput: DW+1 cycles per word minimum.
- Match handling:
  - flag=1 for exactly one cycle, the cycle following the SHIFT cycle that consumed the completing bit.
  - match_cnt increments on the same edge and saturates at 2^CW-1.
  - If cfg_overlap=0, bits_seen clears to 0 on a match, so the next match needs len_eff fresh bits.
- Target:
  - If cfg_target!=0 and the incremented match_cnt equals cfg_target, go to DONE on that edge.
  - Remaining bits of the current word are discarded.
- DONE: done=1 and busy=1 for one cycle, then IDLE. match_cnt holds until the next start.
- Length clamping:
  - len_eff = min(cfg_len, PW).
  - cfg_len=0: no match ever; the run ends only by abort.
- Matches span word boundaries; history persists across LOAD.
- Abort:
  - Any non-IDLE state goes to IDLE on the next edge.
  - No done pulse; match_cnt holds; a flag already in flight still completes its single cycle.
  - Abort has priority over a target hit in the same cycle.
- start while busy is ignored.
- rst mid-run: immediate return to reset values regardless of clock.

Test Plan:
- Overlapping match: pattern=4'b1101, len=4, overlap=1, target=0, word 8'b11011011 -> flag after 4th and 7th SHIFT cycles; match_cnt=2; back to LOAD with s_ready=1.
- Non-overlapping match: same stimulus with overlap=0 -> single flag after 4th bit; match_cnt=1.
- Cross-word match: pattern=4'b0110, len=4, words 8'h03 then 8'h00 -> exactly one flag on the 1st bit of the second word; match_cnt=1.
- Target hit: pattern=1'b1, len=1, target=2, word 8'hFF -> flags after bits 1 and 2; done pulse one cycle later; match_cnt=2; 6 bits discarded; busy=0 afterwards; s_valid held high is not accepted.
- Abort and degenerate length: len=0, word 8'hFF -> no flag; abort in SHIFT -> IDLE next cycle, done=0, busy=0.
- Async reset mid-run: rst=1 mid-SHIFT between edges -> s_ready, flag, busy, done, match_cnt all 0 before the next clock edge.

Source files
------------

// File: rtl/seq_detect_ctrl.sv
// -----------------------------------------------------------------------------
// seq_detect_ctrl
//
// Run-time programmable serial pattern detector. Words arrive over a
// valid/ready handshake, are shifted MSB-first into a bit history, and the
// newest len_eff history bits are compared against the latched pattern after
// every shifted bit. Matches raise a one-cycle flag and bump a saturating
// counter; a non-zero target ends the run with a one-cycle done pulse.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous reset, active-high
//   start        begin a run (sampled only while idle)
//   abort        terminate a run (sampled in any non-idle state)
//   cfg_pattern  pattern; bit [len-1] lines up with the oldest compared bit
//   cfg_len      pattern length in bits (clamped to PW, 0 = never match)
//   cfg_overlap  1 = overlapping matches allowed
//   cfg_target   match count that ends the run, 0 = run until abort
//   s_valid      input word valid
//   s_data       input word
//   s_ready      controller can take a word this cycle
//   flag         one-cycle pulse per match
//   match_cnt    matches counted in the current run (holds after the run)
//   busy         high whenever a run is in progress (any non-idle state)
//   done         one-cycle pulse when the target count is reached
// -----------------------------------------------------------------------------
module seq_detect_ctrl #(
  parameter int DW = 8,
  parameter int PW = 8,
  parameter int CW = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [PW-1:0]         cfg_pattern,
  input  logic [$clog2(PW):0]   cfg_len,
  input  logic                  cfg_overlap,
  input  logic [CW-1:0]         cfg_target,
  input  logic                  s_valid,
  input  logic [DW-1:0]         s_data,
  output logic                  s_ready,
  output logic                  flag,
  output logic [CW-1:0]         match_cnt,
  output logic                  busy,
  output logic                  done
);

  localparam int LW = $clog2(PW) + 1;
  localparam int BW = (DW > 1) ? $clog2(DW) : 1;
  localparam logic [LW-1:0] PW_L    = LW'(PW);
  localparam logic [BW-1:0] BIT_MSB = BW'(DW - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] pat_q,   pat_d;
  logic [LW-1:0] len_q,   len_d;
  logic          ovl_q,   ovl_d;
  logic [CW-1:0] tgt_q,   tgt_d;
  logic [DW-1:0] word_q,  word_d;
  logic [BW-1:0] bit_q,   bit_d;
  logic [PW-1:0] hist_q,  hist_d;
  logic [LW-1:0] seen_q,  seen_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic          flag_q,  flag_d;

  // Match counter saturates at all-ones instead of wrapping.
  function automatic logic [CW-1:0] sat_inc_cnt(input logic [CW-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Number of valid history bits never exceeds the history depth.
  function automatic logic [LW-1:0] sat_inc_seen(input logic [LW-1:0] v);
    return (v >= PW_L) ? PW_L : v + 1'b1;
  endfunction

  function automatic logic [LW-1:0] clamp_len(input logic [LW-1:0] len);
    return (len > PW_L) ? PW_L : len;
  endfunction

  // Ones in the low 'len' positions: selects the bits that take part in
  // the comparison.
  function automatic logic [PW-1:0] len_mask(input logic [LW-1:0] len);
    logic [PW-1:0] m;
    for (int i = 0; i < PW; i++) m[i] = (i < int'(len));
    return m;
  endfunction

  // Shift-path datapath, only consumed while in S_SHIFT.
  logic          shift_bit;
  logic [PW-1:0] hist_shift;
  logic [LW-1:0] seen_inc;
  logic [CW-1:0] cnt_inc;
  logic          hit;
  logic          tgt_hit;

  always_comb begin
    shift_bit  = word_q[bit_q];
    hist_shift = (hist_q << 1) | PW'(shift_bit);
    seen_inc   = sat_inc_seen(seen_q);
    cnt_inc    = sat_inc_cnt(cnt_q);
    // len_q == 0 never matches, so a zero-length run only ends by abort.
    hit        = (len_q != '0) && (seen_inc >= len_q) &&
                 (((hist_shift ^ pat_q) & len_mask(len_q)) == '0);
    tgt_hit    = hit && (tgt_q != '0) && (cnt_inc == tgt_q);
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      pat_q   <= '0;
      len_q   <= '0;
      ovl_q   <= 1'b0;
      tgt_q   <= '0;
      word_q  <= '0;
      bit_q   <= '0;
      hist_q  <= '0;
      seen_q  <= '0;
      cnt_q   <= '0;
      flag_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      ovl_q   <= ovl_d;
      tgt_q   <= tgt_d;
      word_q  <= word_d;
      bit_q   <= bit_d;
      hist_q  <= hist_d;
      seen_q  <= seen_d;
      cnt_q   <= cnt_d;
      flag_q  <= flag_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    len_d   = len_q;
    ovl_d   = ovl_q;
    tgt_d   = tgt_q;
    word_d  = word_q;
    bit_d   = bit_q;
    hist_d  = hist_q;
    seen_d  = seen_q;
    cnt_d   = cnt_q;
    flag_d  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          pat_d   = cfg_pattern;
          len_d   = clamp_len(cfg_len);
          ovl_d   = cfg_overlap;
          tgt_d   = cfg_target;
          hist_d  = '0;
          seen_d  = '0;
          cnt_d   = '0;
          state_d = S_LOAD;
        end
      end

      S_LOAD: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (s_valid) begin
          word_d  = s_data;
          bit_d   = BIT_MSB;
          state_d = S_SHIFT;
        end
      end

      S_SHIFT: begin
        hist_d = hist_shift;
        seen_d = seen_inc;
        bit_d  = bit_q - 1'b1;
        if (hit) begin
          flag_d = 1'b1;
          cnt_d  = cnt_inc;
          // Without overlap the next match must be built from fresh bits.
          if (!ovl_q) seen_d = '0;
        end
        // Abort wins over a target hit; leftover word bits are dropped
        // whenever the run ends mid-word.
        if (abort)                state_d = S_IDLE;
        else if (tgt_hit)         state_d = S_DONE;
        else if (bit_q == '0)     state_d = S_LOAD;
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output logic
  always_comb begin
    s_ready   = (state_q == S_LOAD);
    busy      = (state_q != S_IDLE);
    done      = (state_q == S_DONE);
    flag      = flag_q;
    match_cnt = cnt_q;
  end

endmodule
